// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and requester identities.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_e;

    typedef enum logic {
        REQ_INSTR,
        REQ_DATA
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants taken while fetch was waiting.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int unsigned   CW  = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != LIM))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one req/ack memory port; data wins
// by default, fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    InstrReq,
    input  logic [ADDR_WIDTH-1:0]   InstrAddr,
    input  logic                    InstrFlush,
    output logic [DATA_WIDTH-1:0]   InstrRData,
    output logic                    InstrValid,
    input  logic                    DataReq,
    input  logic                    DataWE,
    input  logic [ADDR_WIDTH-1:0]   DataAddr,
    input  logic [DATA_WIDTH-1:0]   DataWData,
    input  logic [DATA_WIDTH/8-1:0] DataByteEn,
    output logic [DATA_WIDTH-1:0]   DataRData,
    output logic                    DataValid,
    output logic                    MemReq,
    output logic                    MemWE,
    output logic [ADDR_WIDTH-1:0]   MemAddr,
    output logic [DATA_WIDTH-1:0]   MemWData,
    output logic [DATA_WIDTH/8-1:0] MemByteEn,
    input  logic [DATA_WIDTH-1:0]   MemRData,
    input  logic                    MemAck,
    output logic                    InstrStall,
    output logic                    DataStall
);

    arb_state_e              state_q;
    logic                    discard_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH/8-1:0] mem_be_q;

    logic    at_limit;
    req_id_e winner;
    logic    grant_i, grant_d;

    assign winner  = (InstrReq && (!DataReq || at_limit)) ? REQ_INSTR : REQ_DATA;
    assign grant_i = (state_q == IDLE) && InstrReq && (winner == REQ_INSTR);
    assign grant_d = (state_q == IDLE) && DataReq  && (winner == REQ_DATA);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (grant_d && InstrReq),
        .clr_i      (grant_i),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q     <= BUSY_I;
                        discard_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= InstrAddr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                    end else if (grant_d) begin
                        state_q     <= BUSY_D;
                        mem_we_q    <= DataWE;
                        mem_addr_q  <= DataAddr;
                        mem_wdata_q <= DataWData;
                        mem_be_q    <= DataByteEn;
                    end
                end
                BUSY_I: begin
                    // A flush only marks the result dead; the memory cycle still completes.
                    if (MemAck) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                    end else if (InstrFlush) begin
                        discard_q <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (MemAck)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemReq     = (state_q != IDLE);
    assign MemWE      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign MemByteEn  = mem_be_q;

    assign InstrValid = (state_q == BUSY_I) && MemAck && !discard_q && !InstrFlush;
    assign DataValid  = (state_q == BUSY_D) && MemAck;
    assign InstrRData = MemRData;
    assign DataRData  = MemRData;

    assign InstrStall = InstrReq && !InstrValid;
    assign DataStall  = DataReq  && !DataValid;

endmodule
